// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG vector-playback sequencer: FSM state
// encoding and the sticky error codes reported on err.
package jtag_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_GO     = 3'd2,
        ST_WAIT   = 3'd3,
        ST_GAP    = 3'd4,
        ST_FINISH = 3'd5
    } seq_state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_CFG   = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;
    localparam logic [1:0] ERR_ABORT = 2'b11;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter used for both the inter-pass gap and the playback
// watchdog; it holds at zero instead of wrapping.
module seq_down_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/jtag_sequencer.sv
// Runs a JTAG vector range through the player a configurable number of
// times, with idle gaps, optional ADC arming, a watchdog and abort.
module jtag_sequencer
    import jtag_pkg::*;
#(
    parameter int J_A_WIDTH = 12,
    parameter int REP_WIDTH = 16,
    parameter int GAP_WIDTH = 16,
    parameter int TMO_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_start,
    input  logic                 cmd_abort,
    input  logic [J_A_WIDTH-1:0] cfg_vec_start,
    input  logic [J_A_WIDTH-1:0] cfg_vec_end,
    input  logic [REP_WIDTH-1:0] cfg_repeat,
    input  logic [GAP_WIDTH-1:0] cfg_gap,
    input  logic                 cfg_adc_every,
    input  logic                 play_done,
    output logic                 play_go,
    output logic [J_A_WIDTH-1:0] play_addr_start,
    output logic [J_A_WIDTH-1:0] play_addr_end,
    output logic                 adc_start,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err,
    output logic [REP_WIDTH-1:0] pass_cnt
);

    seq_state_t           r_state;
    logic [J_A_WIDTH-1:0] r_addr_start;
    logic [J_A_WIDTH-1:0] r_addr_end;
    logic [REP_WIDTH-1:0] r_repeat;
    logic [GAP_WIDTH-1:0] r_gap;
    logic                 r_adc_every;
    logic [REP_WIDTH-1:0] r_pass_cnt;
    logic                 r_play_go;
    logic                 r_adc_start;
    logic                 r_busy;
    logic                 r_done;
    logic [1:0]           r_err;

    logic                 w_bad_cfg;
    logic [REP_WIDTH:0]   w_pass_plus1;
    logic [REP_WIDTH-1:0] w_rep_eff;
    logic [REP_WIDTH-1:0] w_pass_sat;
    logic                 w_last_pass;
    logic                 w_adc_arm;
    logic                 w_gap_zero;
    logic                 w_wd_zero;
    logic                 w_gap_load;
    logic                 w_wd_load;
    logic                 w_wd_en;

    assign w_bad_cfg    = (r_addr_end < r_addr_start);
    assign w_pass_plus1 = {1'b0, r_pass_cnt} + (REP_WIDTH+1)'(1);
    assign w_rep_eff    = (r_repeat == '0) ? REP_WIDTH'(1) : r_repeat;
    assign w_last_pass  = (w_pass_plus1 == {1'b0, w_rep_eff});
    assign w_pass_sat   = (&r_pass_cnt) ? r_pass_cnt : w_pass_plus1[REP_WIDTH-1:0];
    assign w_adc_arm    = r_adc_every || (r_pass_cnt == '0);

    // The watchdog is loaded on entry to GO so it already counts during GO;
    // expiry then lands exactly 2**TMO_WIDTH cycles after play_go.
    assign w_wd_load  = ((r_state == ST_CHECK) && !w_bad_cfg) ||
                        ((r_state == ST_GAP) && w_gap_zero);
    assign w_wd_en    = (r_state == ST_GO) || (r_state == ST_WAIT);
    assign w_gap_load = (r_state == ST_WAIT) && play_done && !w_last_pass;

    seq_down_counter #(.WIDTH(GAP_WIDTH)) u_gap_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_gap_load),
        .i_load_val (r_gap),
        .i_en       (r_state == ST_GAP),
        .o_zero     (w_gap_zero)
    );

    seq_down_counter #(.WIDTH(TMO_WIDTH)) u_wd_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_wd_load),
        .i_load_val ({TMO_WIDTH{1'b1}}),
        .i_en       (w_wd_en),
        .o_zero     (w_wd_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_addr_start <= '0;
            r_addr_end   <= '0;
            r_repeat     <= '0;
            r_gap        <= '0;
            r_adc_every  <= 1'b0;
            r_pass_cnt   <= '0;
            r_play_go    <= 1'b0;
            r_adc_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= ERR_NONE;
        end else begin
            r_play_go   <= 1'b0;
            r_adc_start <= 1'b0;
            r_done      <= 1'b0;
            if (cmd_abort && (r_state != ST_IDLE)) begin
                r_err   <= ERR_ABORT;
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (cmd_start) begin
                            r_addr_start <= cfg_vec_start;
                            r_addr_end   <= cfg_vec_end;
                            r_repeat     <= cfg_repeat;
                            r_gap        <= cfg_gap;
                            r_adc_every  <= cfg_adc_every;
                            r_pass_cnt   <= '0;
                            r_err        <= ERR_NONE;
                            r_busy       <= 1'b1;
                            r_state      <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (w_bad_cfg) begin
                            r_err   <= ERR_CFG;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_play_go   <= 1'b1;
                            r_adc_start <= w_adc_arm;
                            r_state     <= ST_GO;
                        end
                    end
                    ST_GO: begin
                        r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (play_done) begin
                            r_pass_cnt <= w_pass_sat;
                            if (w_last_pass) begin
                                r_done  <= 1'b1;
                                r_state <= ST_FINISH;
                            end else begin
                                r_state <= ST_GAP;
                            end
                        end else if (w_wd_zero) begin
                            r_err   <= ERR_TMO;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_GAP: begin
                        if (w_gap_zero) begin
                            r_play_go   <= 1'b1;
                            r_adc_start <= w_adc_arm;
                            r_state     <= ST_GO;
                        end
                    end
                    ST_FINISH: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign play_go         = r_play_go;
    assign adc_start       = r_adc_start;
    assign play_addr_start = r_addr_start;
    assign play_addr_end   = r_addr_end;
    assign busy            = r_busy;
    assign done            = r_done;
    assign err             = r_err;
    assign pass_cnt        = r_pass_cnt;

endmodule
